ifu_fetch: RTL and testbench

//  Instruction-fetch unit for the pipelined MIPS core; the initiator side of the instruction-memory read port.

---
 rtl/ifu_fetch.sv | 100 ++++++++++
 tb/tb_ifu_fetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the PC, drives the asynchronous-read IM and loads the IF/ID register.
// Branch/jump redirects follow MIPS delay-slot semantics; fetch halts when the PC leaves the IM window or is misaligned.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_instr,
  output logic [31:0]      pc_f,
  output logic [31:0]      ir_d,
  output logic [31:0]      pc4_d,
  output logic             valid_d,
  output logic             halted,
  output logic [31:0]      fetch_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [31:0] WIN_BYTES = 32'd4 << IM_AW;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] link_q, link_d;
  logic        vld_q, vld_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_off;
  logic        pc_fault;

  // Unsigned offset: a PC below the window base wraps to a huge value and faults too.
  always_comb begin
    pc_off   = pc_q - PC_RESET;
    pc_fault = (pc_q[1:0] != 2'b00) || (pc_off >= WIN_BYTES);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      link_q  <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      link_q  <= link_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    link_d  = link_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (stall) begin
          // D re-presents any redirect once the stall clears.
        end else if (pc_fault) begin
          state_d = HALT;
          instr_d = '0;
          vld_d   = 1'b0;
        end else begin
          instr_d = im_instr;
          link_d  = pc_q + 32'd4;
          vld_d   = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          pc_d    = redirect ? redirect_pc : pc_q + 32'd4;
        end
      end
      HALT: begin
        instr_d = '0;
        vld_d   = 1'b0;
      end
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    im_addr   = pc_q[IM_AW+1:2];
    pc_f      = pc_q;
    ir_d      = instr_q;
    pc4_d     = link_q;
    valid_d   = vld_q;
    halted    = (state_q == HALT);
    fetch_cnt = cnt_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a behavioural fetch model is compared against the DUT at every falling edge,
// with hand-computed literal checks pinning the model along the directed sequence.
module tb_ifu_fetch;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int unsigned IM_AW    = 10;
  localparam int unsigned WORDS    = 1 << IM_AW;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             stall = 1'b0;
  logic             redirect = 1'b0;
  logic [31:0]      redirect_pc = '0;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_instr;
  logic [31:0]      pc_f, ir_d, pc4_d, fetch_cnt;
  logic             valid_d, halted;

  logic [31:0] mem [WORDS];

  int unsigned n_tot  = 0;
  int unsigned n_pass = 0;

  logic [31:0] m_pc, m_ir, m_pc4, m_cnt;
  logic        m_valid, m_halted;

  ifu_fetch #(.PC_RESET(PC_RESET), .IM_AW(IM_AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .im_addr(im_addr), .im_instr(im_instr), .pc_f(pc_f), .ir_d(ir_d), .pc4_d(pc4_d),
    .valid_d(valid_d), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  assign im_instr = mem[im_addr];

  initial begin
    for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0003);
    mem[0] = 32'h3c01_0001;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: fetch is legal only for a word-aligned PC inside [PC_RESET, PC_RESET + 4*WORDS).
  always @(posedge clk) begin
    if (!reset) begin
      m_pc = PC_RESET; m_ir = 0; m_pc4 = 0; m_valid = 0; m_halted = 0; m_cnt = 0;
    end else if (!m_halted && !stall) begin
      if ((m_pc % 4) != 0 || m_pc < PC_RESET || m_pc >= PC_RESET + 4 * WORDS) begin
        m_halted = 1; m_ir = 0; m_valid = 0;
      end else begin
        m_ir    = mem[(m_pc - PC_RESET) / 4];
        m_pc4   = m_pc + 4;
        m_valid = 1;
        m_cnt   = m_cnt + 1;
        m_pc    = redirect ? redirect_pc : m_pc + 4;
      end
    end
  end

  always @(negedge clk) begin
    chk("pc_f", pc_f, m_pc);
    chk("im_addr", 32'(im_addr), (m_pc / 4) % WORDS);
    chk("ir_d", ir_d, m_ir);
    chk("pc4_d", pc4_d, m_pc4);
    chk("valid_d", 32'(valid_d), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("fetch_cnt", fetch_cnt, m_cnt);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("pre_pc", pc_f, 32'h3000);
    chk("pre_im_addr", 32'(im_addr), 0);
    chk("pre_valid", 32'(valid_d), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("first_ir", ir_d, 32'h3c01_0001);
    chk("first_pc4", pc4_d, 32'h3004);
    chk("first_pc", pc_f, 32'h3004);
    chk("first_cnt", fetch_cnt, 1);
    @(negedge clk);
    chk("at_3008", pc_f, 32'h3008);

    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_pc", pc_f, 32'h3008);
      chk("stall_ir", ir_d, 32'hA501_0003);
      chk("stall_pc4", pc4_d, 32'h3008);
      chk("stall_cnt", fetch_cnt, 2);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_ir", ir_d, 32'hA502_0006);
    chk("unstall_pc", pc_f, 32'h300c);

    redirect = 1'b1; redirect_pc = 32'h3040;
    @(negedge clk);
    chk("slot_ir", ir_d, 32'hA503_0009);
    chk("slot_pc", pc_f, 32'h3040);
    redirect = 1'b0;
    @(negedge clk);
    chk("target_ir", ir_d, 32'hA510_0030);
    chk("target_pc4", pc4_d, 32'h3044);

    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3100;
    @(negedge clk);
    chk("stall_redir_pc", pc_f, 32'h3044);
    chk("stall_redir_cnt", fetch_cnt, 5);
    stall = 1'b0;
    @(negedge clk);
    chk("late_redir_pc", pc_f, 32'h3100);
    chk("late_redir_ir", ir_d, 32'hA511_0033);

    redirect_pc = 32'h3002;
    @(negedge clk);
    chk("bad_pc_taken", pc_f, 32'h3002);
    chk("bad_pc_valid", 32'(valid_d), 1);
    redirect = 1'b0;
    @(negedge clk);
    chk("halt_flag", 32'(halted), 1);
    chk("halt_valid", 32'(valid_d), 0);
    chk("halt_ir", ir_d, 0);
    redirect = 1'b1; redirect_pc = 32'h3000;
    repeat (2) @(negedge clk);
    chk("halt_ignores_redir", pc_f, 32'h3002);
    redirect = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("halt_reset_pc", pc_f, 32'h3000);
    chk("halt_reset_flag", 32'(halted), 0);
    reset = 1'b1;

    for (int i = 0; i < 1100 && pc_f != 32'h3ffc; i++) @(negedge clk);
    chk("reach_3ffc", pc_f, 32'h3ffc);
    @(negedge clk);
    chk("last_ir", ir_d, 32'hA6FF_0BFD);
    chk("end_pc", pc_f, 32'h4000);
    @(negedge clk);
    chk("end_halt", 32'(halted), 1);
    chk("end_valid", 32'(valid_d), 0);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_pc", pc_f, 32'h3000);
    chk("mid_rst_ir", ir_d, 0);
    chk("mid_rst_pc4", pc4_d, 0);
    chk("mid_rst_valid", 32'(valid_d), 0);
    chk("mid_rst_cnt", fetch_cnt, 0);
    chk("mid_rst_halt", 32'(halted), 0);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
